// File: rtl/play_command_receiver_pkg.sv
// play_command_receiver_pkg: ASCII codes, parser/UART state encodings and digit test shared by the play receiver
package play_command_receiver_pkg;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  typedef enum logic [3:0] {
    AGUARDA_INICIO = 4'd0,
    RECEBE_DIGITO  = 4'd1,
    AGUARDA_FIM    = 4'd2,
    CONCLUIDO      = 4'd3,
    FALHA          = 4'd4
  } estado_t;
  typedef enum logic [1:0] {OCIOSO, START, DADOS, STOP} uart_estado_t;
  function automatic logic is_digit(input logic [7:0] c);
    return c >= ASCII_ZERO && c <= ASCII_NINE;
  endfunction
endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 receiver (rx_i in; dado_o byte, byte_valido_o good-stop pulse, byte_erro_o framing-error pulse)
module uart_rx_8n1
  import play_command_receiver_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] dado_o,
  output logic       byte_valido_o,
  output logic       byte_erro_o
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  logic [1:0] sync_q;
  uart_estado_t estado_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic rxs;
  assign rxs = sync_q[1];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q        <= 2'b11;
      estado_q      <= OCIOSO;
      cnt_q         <= '0;
      bit_q         <= '0;
      dado_o        <= '0;
      byte_valido_o <= 1'b0;
      byte_erro_o   <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx_i};
      byte_valido_o <= 1'b0;
      byte_erro_o   <= 1'b0;
      cnt_q         <= cnt_q + 1'b1;
      case (estado_q)
        OCIOSO: begin
          cnt_q <= '0;
          if (!rxs) estado_q <= START;
        end
        START: if (cnt_q == HALF) begin
          cnt_q    <= '0;
          bit_q    <= '0;
          estado_q <= rxs ? OCIOSO : DADOS;
        end
        DADOS: if (cnt_q == FULL) begin
          cnt_q  <= '0;
          dado_o <= {rxs, dado_o[7:1]};
          bit_q  <= bit_q + 1'b1;
          if (bit_q == 3'd7) estado_q <= STOP;
        end
        STOP: if (cnt_q == FULL) begin
          byte_valido_o <= rxs;
          byte_erro_o   <= !rxs;
          estado_q      <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end
endmodule

// File: rtl/play_command_receiver.sv
// play_command_receiver: parses '#'+digits+LF from serial rx into BCD jogada (pronto/erro pulses, ocupado, db_estado)
module play_command_receiver
  import play_command_receiver_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  input  logic                    habilita,
  output logic [4*NUM_DIGITS-1:0] jogada,
  output logic                    pronto,
  output logic                    erro,
  output logic                    ocupado,
  output logic [3:0]              db_estado
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam logic [NW-1:0] ULTIMO = NW'(NUM_DIGITS - 1);
  logic [7:0] dado;
  logic byte_valido, byte_erro;
  estado_t estado_q;
  logic [NW-1:0] cnt_q;
  logic [W-1:0] shift_q, shift_d, jogada_q;
  logic pronto_q, erro_q;
  uart_rx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx_i         (rx),
    .dado_o       (dado),
    .byte_valido_o(byte_valido),
    .byte_erro_o  (byte_erro)
  );
  // ASCII '0'..'9' carry their value in the low nibble
  assign shift_d   = W'({shift_q, dado[3:0]});
  assign jogada    = jogada_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign ocupado   = estado_q != AGUARDA_INICIO;
  assign db_estado = estado_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= AGUARDA_INICIO;
      cnt_q    <= '0;
      shift_q  <= '0;
      jogada_q <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      if (byte_valido && dado == ASCII_HASH) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end
      if (!habilita) estado_q <= AGUARDA_INICIO;
      else case (estado_q)
        AGUARDA_INICIO: begin
          if (byte_erro) estado_q <= FALHA;
          else if (byte_valido && dado == ASCII_HASH) estado_q <= RECEBE_DIGITO;
        end
        RECEBE_DIGITO: begin
          if (byte_erro) estado_q <= FALHA;
          else if (byte_valido && dado != ASCII_HASH) begin
            if (is_digit(dado)) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == ULTIMO) estado_q <= AGUARDA_FIM;
            end else estado_q <= FALHA;
          end
        end
        AGUARDA_FIM: begin
          if (byte_erro) estado_q <= FALHA;
          else if (byte_valido)
            estado_q <= dado == ASCII_LF ? CONCLUIDO : dado == ASCII_HASH ? RECEBE_DIGITO : FALHA;
        end
        CONCLUIDO: begin
          jogada_q <= shift_q;
          pronto_q <= 1'b1;
          estado_q <= AGUARDA_INICIO;
        end
        FALHA: begin
          erro_q   <= 1'b1;
          estado_q <= AGUARDA_INICIO;
        end
        default: estado_q <= AGUARDA_INICIO;
      endcase
    end
  end
endmodule

// File: tb/tb_play_command_receiver.sv
// tb_play_command_receiver: randomized and directed bench against a message-level model of the play receiver
module tb_play_command_receiver;
  localparam int B = 8;
  localparam int N = 2;
  logic clock = 0, reset = 1, rx = 1, habilita = 1;
  logic [4*N-1:0] jogada;
  logic pronto, erro, ocupado;
  logic [3:0] db_estado;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_start = 0, last_pronto_cyc = -1;
  int mon_pronto = 0, mon_erro = 0, mon_both = 0, mon_jglitch = 0;
  logic [4*N-1:0] prev_jog = '0;
  bit m_active = 0;
  int m_digits[$];
  logic [4*N-1:0] m_jog = '0;
  int m_pronto = 0, m_erro = 0;

  play_command_receiver #(.BAUD_DIV(B), .NUM_DIGITS(N)) dut (
    .clock(clock), .reset(reset), .rx(rx), .habilita(habilita),
    .jogada(jogada), .pronto(pronto), .erro(erro), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (!reset) begin
      if (pronto) begin mon_pronto++; last_pronto_cyc = cyc; end
      if (erro) mon_erro++;
      if (pronto && erro) mon_both++;
      if (jogada !== prev_jog && !pronto) mon_jglitch++;
    end
    prev_jog = jogada;
  end

  // Message-level reference: a '#' opens a message, exactly N digits then LF yields a play
  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [4*N-1:0] v;
    if (!habilita) return;
    if (!ok) begin m_erro++; m_active = 0; end
    else if (b == 8'h23) begin m_active = 1; m_digits.delete(); end
    else if (!m_active) ;
    else if (b >= 8'h30 && b <= 8'h39 && m_digits.size() < N) m_digits.push_back(int'(b) - 48);
    else if (b == 8'h0A && m_digits.size() == N) begin
      v = '0;
      foreach (m_digits[i]) v = (v << 4) | (4*N)'(m_digits[i]);
      m_jog = v; m_pronto++; m_active = 0;
    end else begin m_erro++; m_active = 0; end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start = cyc;
    drive(1'b0, B);
    for (int i = 0; i < 8; i++) drive(b[i], B);
    drive(stop, B);
    if (!stop) drive(1'b1, B);
    model_byte(b, stop);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic set_en(input logic v);
    habilita = v;
    if (!v) m_active = 0;
  endtask

  task automatic test_reset;
    #1;
    n_tests += 5;
    if (jogada !== '0) begin n_fail++; $display("FAIL reset_jogada: got %0h expected 0", jogada); end
    if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
    if (erro !== 1'b0) begin n_fail++; $display("FAIL reset_erro: got %b expected 0", erro); end
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_db_estado: got %0d expected 0", db_estado); end
    repeat (3) @(posedge clock);
    #1 reset = 0;
    drive(1'b1, 4);
  endtask

  task automatic test_valid;
    send_str("#37\n");
    drive(1'b1, 6);
    n_tests += 4;
    if (jogada !== 8'h37) begin n_fail++; $display("FAIL valid_jogada: got %0h expected 37", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL valid_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL valid_erro: got %0d expected %0d", mon_erro, m_erro); end
    if (last_pronto_cyc < last_start + 9*B || last_pronto_cyc > last_start + 10*B + 3) begin
      n_fail++; $display("FAIL valid_latency: got pronto at %0d expected in [%0d,%0d]", last_pronto_cyc, last_start + 9*B, last_start + 10*B + 3);
    end
  endtask

  task automatic test_bad_char;
    send_str("#3A\n");
    drive(1'b1, 6);
    n_tests += 3;
    if (jogada !== 8'h37) begin n_fail++; $display("FAIL badchar_jogada: got %0h expected 37", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL badchar_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL badchar_erro: got %0d expected %0d", mon_erro, m_erro); end
  endtask

  task automatic test_restart;
    send_str("#1#42\n");
    drive(1'b1, 6);
    n_tests += 3;
    if (jogada !== 8'h42) begin n_fail++; $display("FAIL restart_jogada: got %0h expected 42", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL restart_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL restart_erro: got %0d expected %0d", mon_erro, m_erro); end
    send_str("#425\n");
    drive(1'b1, 6);
    n_tests += 3;
    if (jogada !== 8'h42) begin n_fail++; $display("FAIL oversize_jogada: got %0h expected 42", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL oversize_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL oversize_erro: got %0d expected %0d", mon_erro, m_erro); end
  endtask

  task automatic test_framing;
    int e0;
    send_byte("X", 1'b0);
    drive(1'b1, 4);
    n_tests++;
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL framing_erro: got %0d expected %0d", mon_erro, m_erro); end
    send_str("#09\n");
    drive(1'b1, 6);
    n_tests += 2;
    if (jogada !== 8'h09) begin n_fail++; $display("FAIL framing_jogada: got %0h expected 09", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL framing_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    e0 = mon_erro;
    drive(1'b0, 2);
    drive(1'b1, 4*B);
    n_tests += 2;
    if (mon_erro !== e0) begin n_fail++; $display("FAIL glitch_erro: got %0d expected %0d", mon_erro, e0); end
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL glitch_ocupado: got %b expected 0", ocupado); end
  endtask

  task automatic test_habilita;
    set_en(1'b0);
    send_str("#55\n");
    drive(1'b1, 6);
    n_tests += 3;
    if (jogada !== 8'h09) begin n_fail++; $display("FAIL disabled_jogada: got %0h expected 09", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL disabled_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL disabled_erro: got %0d expected %0d", mon_erro, m_erro); end
    set_en(1'b1);
    send_str("#5");
    set_en(1'b0);
    drive(1'b1, 3);
    n_tests++;
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL drop_ocupado: got %b expected 0", ocupado); end
    set_en(1'b1);
    send_str("#66\n");
    drive(1'b1, 6);
    n_tests += 3;
    if (jogada !== 8'h66) begin n_fail++; $display("FAIL reenable_jogada: got %0h expected 66", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL reenable_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL reenable_erro: got %0d expected %0d", mon_erro, m_erro); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] c;
    c = "7";
    send_byte(8'h23, 1'b1);
    drive(1'b1, 3);
    n_tests += 2;
    if (ocupado !== 1'b1) begin n_fail++; $display("FAIL partial_ocupado: got %b expected 1", ocupado); end
    if (db_estado !== 4'd1) begin n_fail++; $display("FAIL partial_db_estado: got %0d expected 1", db_estado); end
    drive(1'b0, B);
    for (int i = 0; i < 3; i++) drive(c[i], B);
    reset = 1;
    rx = 1;
    #1;
    m_jog = '0;
    m_active = 0;
    n_tests += 5;
    if (jogada !== '0) begin n_fail++; $display("FAIL midreset_jogada: got %0h expected 0", jogada); end
    if (pronto !== 1'b0) begin n_fail++; $display("FAIL midreset_pronto: got %b expected 0", pronto); end
    if (erro !== 1'b0) begin n_fail++; $display("FAIL midreset_erro: got %b expected 0", erro); end
    if (ocupado !== 1'b0) begin n_fail++; $display("FAIL midreset_ocupado: got %b expected 0", ocupado); end
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL midreset_db_estado: got %0d expected 0", db_estado); end
    repeat (3) @(posedge clock);
    #1 reset = 0;
    drive(1'b1, 4);
    send_str("#12\n");
    drive(1'b1, 6);
    n_tests += 3;
    if (jogada !== 8'h12) begin n_fail++; $display("FAIL postreset_jogada: got %0h expected 12", jogada); end
    if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL postreset_pronto: got %0d expected %0d", mon_pronto, m_pronto); end
    if (mon_erro !== m_erro) begin n_fail++; $display("FAIL postreset_erro: got %0d expected %0d", mon_erro, m_erro); end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] g;
    int r, bad;
    for (int m = 0; m < 30; m++) begin
      q.delete();
      r = $urandom_range(0, 6);
      if (r == 4) begin
        g = 8'($urandom_range(0, 255));
        q.push_back(g == 8'h23 ? 8'h24 : g);
      end
      q.push_back(8'h23);
      if (r == 3) begin q.push_back(8'h30 + 8'($urandom_range(0, 9))); q.push_back(8'h23); end
      q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      if (r == 1) q.push_back(8'h41 + 8'($urandom_range(0, 25)));
      else if (r != 6) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      if (r == 2) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
      q.push_back(8'h0A);
      bad = (r == 5) ? $urandom_range(0, q.size() - 1) : -1;
      foreach (q[i]) begin
        send_byte(q[i], i != bad);
        if ($urandom_range(0, 1) != 0) drive(1'b1, $urandom_range(1, 2*B));
      end
      drive(1'b1, 6);
      n_tests += 3;
      if (jogada !== m_jog) begin n_fail++; $display("FAIL rand%0d_jogada: got %0h expected %0h", m, jogada, m_jog); end
      if (mon_pronto !== m_pronto) begin n_fail++; $display("FAIL rand%0d_pronto: got %0d expected %0d", m, mon_pronto, m_pronto); end
      if (mon_erro !== m_erro) begin n_fail++; $display("FAIL rand%0d_erro: got %0d expected %0d", m, mon_erro, m_erro); end
    end
  endtask

  task automatic test_invariants;
    n_tests += 2;
    if (mon_both !== 0) begin n_fail++; $display("FAIL pronto_erro_overlap: got %0d cycles expected 0", mon_both); end
    if (mon_jglitch !== 0) begin n_fail++; $display("FAIL jogada_unstable: got %0d changes without pronto expected 0", mon_jglitch); end
  endtask

  initial begin
    test_reset;
    test_valid;
    test_bad_char;
    test_restart;
    test_framing;
    test_habilita;
    test_reset_mid;
    test_random;
    test_invariants;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
